// File: rtl/apb_master_ctrl.sv
// APB initiator for two 8-bit APB slaves, fed by a valid/ready command port.
// Each command becomes one SETUP and one or more ACCESS cycles, with a wait timeout.
module apb_master_ctrl #(
    parameter int SEL_BIT = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       psel1,
    output logic       psel2,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic       pready1,
    input  logic       pready2,
    input  logic [7:0] prdata1,
    input  logic [7:0] prdata2
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic            TO_EN     = (TIMEOUT != 0);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_rdata;
    logic             r_rsp_err;
    logic             r_psel1;
    logic             r_psel2;
    logic             r_penable;
    logic             r_pwrite;
    logic [7:0]       r_paddr;
    logic [7:0]       r_pwdata;

    logic             w_sel2;
    logic             w_pready;
    logic [7:0]       w_prdata;
    logic             w_timeout;

    // Route the handshake of whichever slave the latched address selects.
    assign w_sel2    = r_paddr[SEL_BIT];
    assign w_pready  = w_sel2 ? pready2 : pready1;
    assign w_prdata  = w_sel2 ? prdata2 : prdata1;
    assign w_timeout = TO_EN && (r_cnt == TO_LAST);

    // Main FSM: IDLE accepts a command, SETUP lasts one cycle, ACCESS waits for pready.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b0;
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 8'h00;
            r_pwdata    <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
                        r_psel1     <= ~cmd_addr[SEL_BIT];
                        r_psel2     <= cmd_addr[SEL_BIT];
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        r_psel1     <= 1'b0;
                        r_psel2     <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_pwrite ? 8'h00 : w_prdata;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_timeout) begin
                        r_psel1     <= 1'b0;
                        r_psel2     <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 8'h00;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel1     <= 1'b0;
                    r_psel2     <= 1'b0;
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel1     = r_psel1;
    assign psel2     = r_psel2;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with two small slave memories.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_apb_master_ctrl;

    logic       pclk = 1'b0;
    logic       preset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel1;
    logic       psel2;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pready1;
    logic       pready2;
    logic [7:0] prdata1;
    logic [7:0] prdata2;

    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 pclk = ~pclk;

    assign prdata1 = mem1[paddr[4:0]];
    assign prdata2 = mem2[paddr[4:0]];

    apb_master_ctrl dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel1     (psel1),
        .psel2     (psel2),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready1   (pready1),
        .pready2   (pready2),
        .prdata1   (prdata1),
        .prdata2   (prdata2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // waits < 0 means the slave never answers.
    task automatic txn(input string tag, input logic wr,
                       input logic [7:0] addr, input logic [7:0] wdata,
                       input int waits, input logic [7:0] exp_rdata,
                       input logic exp_err, input int exp_cyc);
        logic s2;
        int   cyc;
        s2 = addr[5];
        chk({tag, ".idle_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        pready1   = 1'b0;
        pready2   = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = 8'hFF;
        cmd_wdata = 8'h00;
        chk({tag, ".setup_psel1"}, psel1, !s2);
        chk({tag, ".setup_psel2"}, psel2, s2);
        chk({tag, ".setup_penable"}, penable, 1'b0);
        chk({tag, ".setup_ready"}, cmd_ready, 1'b0);
        chk({tag, ".paddr"}, paddr, addr);
        chk({tag, ".pwrite"}, pwrite, wr);
        if (wr) chk({tag, ".pwdata"}, pwdata, wdata);
        @(negedge pclk);
        cyc = 0;
        while (1) begin
            chk({tag, ".acc_penable"}, penable, 1'b1);
            chk({tag, ".acc_psel1"}, psel1, !s2);
            chk({tag, ".acc_psel2"}, psel2, s2);
            chk({tag, ".acc_paddr"}, paddr, addr);
            chk({tag, ".acc_rsp"}, rsp_valid, 1'b0);
            if (s2) begin
                pready1 = 1'b1;
                pready2 = (waits >= 0 && cyc == waits);
            end else begin
                pready2 = 1'b1;
                pready1 = (waits >= 0 && cyc == waits);
            end
            if (wr && waits >= 0 && cyc == waits) begin
                if (s2) mem2[addr[4:0]] = wdata;
                else    mem1[addr[4:0]] = wdata;
            end
            @(negedge pclk);
            cyc++;
            if (rsp_valid) break;
            if (cyc > 40) break;
        end
        pready1 = 1'b0;
        pready2 = 1'b0;
        chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, ".acc_cycles"}, cyc, exp_cyc);
        chk({tag, ".rsp_err"}, rsp_err, exp_err);
        chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".end_psel1"}, psel1, 1'b0);
        chk({tag, ".end_psel2"}, psel2, 1'b0);
        chk({tag, ".end_penable"}, penable, 1'b0);
        chk({tag, ".end_ready"}, cmd_ready, 1'b1);
        @(negedge pclk);
        chk({tag, ".rsp_pulse"}, rsp_valid, 1'b0);
        chk({tag, ".rdata_hold"}, rsp_rdata, exp_rdata);
        chk({tag, ".err_hold"}, rsp_err, exp_err);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        pready1   = 1'b0;
        pready2   = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("rst.cmd_ready", cmd_ready, 1'b1);
        chk("rst.psel1", psel1, 1'b0);
        chk("rst.psel2", psel2, 1'b0);
        chk("rst.penable", penable, 1'b0);
        chk("rst.pwrite", pwrite, 1'b0);
        chk("rst.paddr", paddr, 8'h00);
        chk("rst.pwdata", pwdata, 8'h00);
        chk("rst.rsp_valid", rsp_valid, 1'b0);
        chk("rst.rsp_err", rsp_err, 1'b0);
        chk("rst.rsp_rdata", rsp_rdata, 8'h00);
        preset = 1'b0;
        @(negedge pclk);
        chk("idle.psel1", psel1, 1'b0);

        txn("wr1",  1'b1, 8'h03, 8'hA5, 0,  8'h00, 1'b0, 1);
        txn("rd1",  1'b0, 8'h03, 8'h00, 0,  8'hA5, 1'b0, 1);
        txn("wr2",  1'b1, 8'h25, 8'h3C, 0,  8'h00, 1'b0, 1);
        txn("rd2",  1'b0, 8'h25, 8'h00, 0,  8'h3C, 1'b0, 1);
        txn("rd1b", 1'b0, 8'h05, 8'h00, 0,  8'h00, 1'b0, 1);
        txn("wait", 1'b1, 8'h1F, 8'h5A, 3,  8'h00, 1'b0, 4);
        txn("rdw",  1'b0, 8'h1F, 8'h00, 2,  8'h5A, 1'b0, 3);
        txn("to1",  1'b0, 8'h07, 8'h00, -1, 8'h00, 1'b1, 16);
        txn("to2",  1'b0, 8'h3F, 8'h00, -1, 8'h00, 1'b1, 16);
        txn("post", 1'b0, 8'h25, 8'h00, 1,  8'h3C, 1'b0, 2);

        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h0A;
        cmd_wdata = 8'h77;
        @(negedge pclk);
        @(negedge pclk);
        chk("abort.in_access", penable, 1'b1);
        preset = 1'b1;
        @(negedge pclk);
        preset    = 1'b0;
        cmd_valid = 1'b0;
        chk("abort.psel1", psel1, 1'b0);
        chk("abort.psel2", psel2, 1'b0);
        chk("abort.penable", penable, 1'b0);
        chk("abort.cmd_ready", cmd_ready, 1'b1);
        chk("abort.rsp_valid", rsp_valid, 1'b0);
        @(negedge pclk);
        chk("abort.no_rsp", rsp_valid, 1'b0);
        txn("after", 1'b0, 8'h03, 8'h00, 0, 8'hA5, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
